// File: rtl/adder_result_checker.sv
// Response-side checker for adder regressions: per-vector mismatch flag, vector/error
// counters, first-failure index and a 32-bit MISR signature of the DUV responses.
module adder_result_checker #(
  parameter int unsigned n        = 256,
  parameter int unsigned type_sel = 1,   // "type" is a reserved word; 1 also compares prop/gen
  parameter int unsigned cnt_w    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic             last,
  input  logic [n-1:0]     s_ref,
  input  logic [n-1:0]     s_duv,
  input  logic             cout_ref,
  input  logic             cout_duv,
  input  logic             prop_ref,
  input  logic             prop_duv,
  input  logic             gen_ref,
  input  logic             gen_duv,
  output logic             err,
  output logic [cnt_w-1:0] vec_count,
  output logic [cnt_w-1:0] err_count,
  output logic [cnt_w-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic [31:0]      signature,
  output logic             done,
  output logic             pass
);

  localparam int unsigned NS = (n + 31) / 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic               err_q, err_d;
  logic [cnt_w-1:0]   vec_q, vec_d;
  logic [cnt_w-1:0]   errc_q, errc_d;
  logic [cnt_w-1:0]   fidx_q, fidx_d;
  logic               fval_q, fval_d;
  logic [31:0]        sig_q, sig_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [NS*32-1:0]   s_pad;
  logic [31:0]        fold;
  logic               fb;
  logic               mis;
  logic               accept;

  // Fold the sum into 32 bits (top slice zero-padded) and mix in the single-bit outputs.
  always_comb begin
    s_pad          = '0;
    s_pad[n-1:0]   = s_duv;
    fold           = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      fold = fold ^ s_pad[i*32 +: 32];
    end
    fold[0] = fold[0] ^ cout_duv;
    if (type_sel != 0) begin
      fold[1] = fold[1] ^ prop_duv;
      fold[2] = fold[2] ^ gen_duv;
    end
    fb = sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0];
  end

  // Case inequality so that X/Z on any compared input is reported as a mismatch.
  always_comb begin
    mis = (s_ref !== s_duv) || (cout_ref !== cout_duv);
    if (type_sel != 0) begin
      mis = mis || (prop_ref !== prop_duv) || (gen_ref !== gen_duv);
    end
  end

  assign accept = valid && !clear && (state_q != DONE);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    vec_d   = vec_q;
    errc_d  = errc_q;
    fidx_d  = fidx_q;
    fval_d  = fval_q;
    sig_d   = sig_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (clear) begin
      state_d = IDLE;
      vec_d   = '0;
      errc_d  = '0;
      fidx_d  = '0;
      fval_d  = 1'b0;
      sig_d   = '1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else if (accept) begin
      err_d = mis;
      vec_d = vec_q + cnt_w'(1);
      if (mis && (errc_q != '1)) begin
        errc_d = errc_q + cnt_w'(1);
      end
      if (mis && !fval_q) begin
        fidx_d = vec_q;
        fval_d = 1'b1;
      end
      sig_d = {sig_q[30:0], fb} ^ fold;
      if (state_q == IDLE) begin
        state_d = RUN;
      end else if (last) begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = (errc_d == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      vec_q   <= '0;
      errc_q  <= '0;
      fidx_q  <= '0;
      fval_q  <= 1'b0;
      sig_q   <= '1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      errc_q  <= errc_d;
      fidx_q  <= fidx_d;
      fval_q  <= fval_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign err             = err_q;
  assign vec_count       = vec_q;
  assign err_count       = errc_q;
  assign first_err_idx   = fidx_q;
  assign first_err_valid = fval_q;
  assign signature       = sig_q;
  assign done            = done_q;
  assign pass            = pass_q;

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Synthesizable response-side checker for adder regressions; the counterpart of the stimulus reader that drives cin/a/b.
- Samples reference-adder and DUV outputs on each valid vector and flags mismatches per vector.
- Accumulates vector and error counts, captures the first failing vector index, and compacts DUV responses into a 32-bit MISR signature.
- Sits beside the DUV in the adder benches (cra/csa/cla/a1csa families); also usable on-chip as a BIST result collector.

Parameters:
- n, 256, operand/sum width.
- type, 1, 0 = compare s/cout only {csa,cra,a1csa}; 1 = also compare prop/gen {cla,a1csah}.
- cnt_w, 32, width of vector/error counters and index.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous return to IDLE; zeroes counters, index and signature
- valid  in  1  current s/cout/prop/gen are a vector to check
- last  in  1  with valid: final vector of the run
- s_ref  in  n  reference sum
- s_duv  in  n  DUV sum
- cout_ref, cout_duv  in  1  carry outs
- prop_ref, prop_duv, gen_ref, gen_duv  in  1  group propagate/generate (ignored when type=0)
- err  out  1  registered per-vector mismatch flag
- vec_count  out  cnt_w  vectors checked
- err_count  out  cnt_w  mismatching vectors
- first_err_idx  out  cnt_w  vec_count value of the first mismatch
- first_err_valid  out  1  first_err_idx is meaningful
- signature  out  32  MISR contents
- done  out  1  run finished (level)
- pass  out  1  done and err_count==0

Behaviour:
- Reset (async, any state): all outputs 0, state=IDLE, signature=32'hFFFF_FFFF.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on the first valid; that vector is checked.
  - RUN -> DONE on valid&&last; that vector is checked.
  - DONE holds; valid is ignored.
  - clear in any state -> IDLE with counters 0 and signature reseeded; clear wins over a simultaneous valid.
- Mismatch: mis = (s_ref!=s_duv)|(cout_ref!=cout_duv)|(type ? (prop_ref!=prop_duv)|(gen_ref!=gen_duv) : 0).
- Per accepted vector (valid in IDLE/RUN):
  - err <= mis; vec_count += 1.
  - err_count += mis; err_count saturates at all-ones.
  - vec_count wraps modulo 2^cnt_w.
  - If mis && !first_err_valid: first_err_idx <= pre-increment vec_count (0-based index), first_err_valid <= 1.
- err cycle without an accepted vector: err <= 0, so err is a one-cycle pulse per failing vector.
- Latency: every output updates on the clock edge that samples valid (1 cycle after inputs are presented).
- done and pass rise on the same edge as the last vector's count update.
- MISR:
  - fold = XOR of the n/32 32-bit slices of s_duv; if n is not a multiple of 32, zero-pad the top slice.
  - fold[0] ^= cout_duv. When type=1: fold[1] ^= prop_duv and fold[2] ^= gen_duv.
  - Next = {sig[30:0], fb} ^ fold, where fb = sig[31]^sig[21]^sig[1]^sig[0] (x^32+x^22+x^2+x+1).
  - Updates only on accepted vectors.
- X on the compare inputs counts as a mismatch when valid=1; the comparison uses !==.
- last without valid has no effect.

Test Plan:
- Reset, then 4 vectors with identical ref/duv, last on the 4th:
  - vec_count=4, err_count=0, done=1, pass=1, first_err_valid=0.
  - signature equals the golden-model value.
- 10 vectors, s_duv bit 0 flipped on indices 3 and 7:
  - err pulses exactly twice; err_count=2; first_err_idx=3; pass=0 after last.
- type=0, prop_duv!=prop_ref on every vector, sums equal:
  - err_count=0.
  - Repeat with type=1: err_count equals the vector count.
- Valid deasserted for 5 cycles mid-run:
  - counters and signature hold, err=0.
  - valid asserted together with clear: vec_count=0, state IDLE.
- rst pulsed mid-run between clock edges:
  - outputs clear immediately (without waiting for clk); signature=FFFF_FFFF.
  - the next valid restarts counting at 0.
- After DONE, apply 3 more valid vectors:
  - counts and signature unchanged.
  - clear then 1 vector: vec_count=1.
